// File: rtl/vga_scanout.sv
// vga_scanout: plot-stream framebuffer (160x120x3) scanned out as 640x480@60 VGA.
// Optional framebuffer clear engine: define SCANOUT_CLEAR_EN.
module vga_scanout #(
    parameter int H_VIS = 640,
    parameter int H_FP  = 16,
    parameter int H_SW  = 96,
    parameter int H_BP  = 48,
    parameter int V_VIS = 480,
    parameter int V_FP  = 10,
    parameter int V_SW  = 2,
    parameter int V_BP  = 33,
    parameter int FB_W  = 160,
    parameter int FB_H  = 120
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] x,
    input  logic [9:0] y,
    input  logic [2:0] colour,
    input  logic       plot,
    input  logic       clear,
    output logic       clear_busy,
    output logic       frame_start,
    output logic       VGA_CLK,
    output logic       VGA_HS,
    output logic       VGA_VS,
    output logic       VGA_BLANK_N,
    output logic       VGA_SYNC_N,
    output logic [9:0] VGA_R,
    output logic [9:0] VGA_G,
    output logic [9:0] VGA_B
);

    localparam int H_TOT  = H_VIS + H_FP + H_SW + H_BP;
    localparam int V_TOT  = V_VIS + V_FP + V_SW + V_BP;
    localparam int HS_ON  = H_VIS + H_FP;
    localparam int HS_OFF = HS_ON + H_SW - 1;
    localparam int VS_ON  = V_VIS + V_FP;
    localparam int VS_OFF = VS_ON + V_SW - 1;
    localparam int FB_SZ  = FB_W * FB_H;

    logic [2:0]  fb_mem [0:FB_SZ-1];

    logic        pix_en_q, pix_en_d;
    logic [9:0]  hcount_q, hcount_d;
    logic [9:0]  vcount_q, vcount_d;
    logic        frame_start_q, frame_start_d;

    logic        hs1_q, hs1_d;
    logic        vs1_q, vs1_d;
    logic        vis1_q, vis1_d;
    logic [2:0]  rd_data_q;

    logic        hs2_q, hs2_d;
    logic        vs2_q, vs2_d;
    logic        vis2_q, vis2_d;
    logic [9:0]  r2_q, r2_d;
    logic [9:0]  g2_q, g2_d;
    logic [9:0]  b2_q, b2_d;

    logic        hs0, vs0, vis0;
    logic [14:0] rd_addr;

    logic        plot_ok;
    logic [14:0] plot_addr;
    logic        fb_we;
    logic [14:0] fb_wa;
    logic [2:0]  fb_wd;

    // Stage 0: decode sync/visible terms and the scan read address
    always_comb begin
        vis0 = (hcount_q < 10'(H_VIS)) && (vcount_q < 10'(V_VIS));
        hs0  = !((hcount_q >= 10'(HS_ON)) && (hcount_q <= 10'(HS_OFF)));
        vs0  = !((vcount_q >= 10'(VS_ON)) && (vcount_q <= 10'(VS_OFF)));
        rd_addr = '0;
        if (vis0) begin
            rd_addr = {vcount_q[9:2], 7'b0}
                    + {2'b0, vcount_q[9:2], 5'b0}
                    + {7'b0, hcount_q[9:2]};
        end
    end

    // Plot address (y*160 + x); out-of-range plots never reach the RAM
    always_comb begin
        plot_ok   = plot && (x < 10'(FB_W)) && (y < 10'(FB_H));
        plot_addr = {1'b0, y[6:0], 7'b0}
                  + {3'b0, y[6:0], 5'b0}
                  + {7'b0, x[7:0]};
    end

`ifdef SCANOUT_CLEAR_EN
    logic        clr_busy_q, clr_busy_d;
    logic [14:0] clr_addr_q, clr_addr_d;

    // Clear sequencer: sweeps every address once, restart on a new request
    always_comb begin
        clr_busy_d = clr_busy_q;
        clr_addr_d = clr_addr_q;
        if (clear) begin
            clr_busy_d = 1'b1;
            clr_addr_d = '0;
        end else if (clr_busy_q) begin
            if (clr_addr_q == 15'(FB_SZ - 1)) begin
                clr_busy_d = 1'b0;
            end else begin
                clr_addr_d = clr_addr_q + 15'd1;
            end
        end
    end

    // Clear sequencer state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clr_busy_q <= 1'b0;
            clr_addr_q <= '0;
        end else begin
            clr_busy_q <= clr_busy_d;
            clr_addr_q <= clr_addr_d;
        end
    end

    // Write port mux: clearing wins, plots are dropped while it runs
    always_comb begin
        fb_we = 1'b0;
        fb_wa = plot_addr;
        fb_wd = colour;
        if (clr_busy_q && !clear) begin
            fb_we = 1'b1;
            fb_wa = clr_addr_q;
            fb_wd = 3'b000;
        end else if (!clr_busy_q && !clear) begin
            fb_we = plot_ok;
        end
    end

    assign clear_busy = clr_busy_q;
`else
    logic unused_clear;
    assign unused_clear = clear;

    // Write port: plot stream only
    always_comb begin
        fb_we = plot_ok;
        fb_wa = plot_addr;
        fb_wd = colour;
    end

    assign clear_busy = 1'b0;
`endif

    // Framebuffer RAM: one write port, registered scan read (old data on collision)
    always_ff @(posedge clk) begin
        if (fb_we) begin
            fb_mem[fb_wa] <= fb_wd;
        end
        if (pix_en_q) begin
            rd_data_q <= fb_mem[rd_addr];
        end
    end

    // Scan counters and the two delay stages, advancing on pixel ticks
    always_comb begin
        pix_en_d      = ~pix_en_q;
        hcount_d      = hcount_q;
        vcount_d      = vcount_q;
        frame_start_d = 1'b0;
        hs1_d         = hs1_q;
        vs1_d         = vs1_q;
        vis1_d        = vis1_q;
        hs2_d         = hs2_q;
        vs2_d         = vs2_q;
        vis2_d        = vis2_q;
        r2_d          = r2_q;
        g2_d          = g2_q;
        b2_d          = b2_q;
        if (pix_en_q) begin
            hs1_d  = hs0;
            vs1_d  = vs0;
            vis1_d = vis0;
            hs2_d  = hs1_q;
            vs2_d  = vs1_q;
            vis2_d = vis1_q;
            r2_d   = {10{rd_data_q[2] & vis1_q}};
            g2_d   = {10{rd_data_q[1] & vis1_q}};
            b2_d   = {10{rd_data_q[0] & vis1_q}};
            if (hcount_q == 10'(H_TOT - 1)) begin
                hcount_d = '0;
                if (vcount_q == 10'(V_TOT - 1)) begin
                    vcount_d      = '0;
                    frame_start_d = 1'b1;
                end else begin
                    vcount_d = vcount_q + 10'd1;
                end
            end else begin
                hcount_d = hcount_q + 10'd1;
            end
        end
    end

    // Scan state registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pix_en_q      <= 1'b0;
            hcount_q      <= '0;
            vcount_q      <= '0;
            frame_start_q <= 1'b0;
            hs1_q         <= 1'b1;
            vs1_q         <= 1'b1;
            vis1_q        <= 1'b0;
            hs2_q         <= 1'b1;
            vs2_q         <= 1'b1;
            vis2_q        <= 1'b0;
            r2_q          <= '0;
            g2_q          <= '0;
            b2_q          <= '0;
        end else begin
            pix_en_q      <= pix_en_d;
            hcount_q      <= hcount_d;
            vcount_q      <= vcount_d;
            frame_start_q <= frame_start_d;
            hs1_q         <= hs1_d;
            vs1_q         <= vs1_d;
            vis1_q        <= vis1_d;
            hs2_q         <= hs2_d;
            vs2_q         <= vs2_d;
            vis2_q        <= vis2_d;
            r2_q          <= r2_d;
            g2_q          <= g2_d;
            b2_q          <= b2_d;
        end
    end

    assign frame_start = frame_start_q;
    assign VGA_CLK     = pix_en_q;
    assign VGA_HS      = hs2_q;
    assign VGA_VS      = vs2_q;
    assign VGA_BLANK_N = vis2_q;
    assign VGA_SYNC_N  = 1'b1;
    assign VGA_R       = r2_q;
    assign VGA_G       = g2_q;
    assign VGA_B       = b2_q;

endmodule

// File: tb/tb_vga_scanout.sv
// tb_vga_scanout: directed checks for vga_scanout on a shrunken raster
// (48x32 visible, 64x38 total) so several frames fit in a short run.
module tb_vga_scanout;

    localparam int H_VIS = 48;
    localparam int H_FP  = 4;
    localparam int H_SW  = 8;
    localparam int H_BP  = 4;
    localparam int V_VIS = 32;
    localparam int V_FP  = 2;
    localparam int V_SW  = 2;
    localparam int V_BP  = 2;
    localparam int H_TOT = 64;
    localparam int V_TOT = 38;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [9:0] x = '0;
    logic [9:0] y = '0;
    logic [2:0] colour = '0;
    logic       plot = 1'b0;
    logic       clear = 1'b0;
    logic       clear_busy, frame_start;
    logic       VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N;
    logic [9:0] VGA_R, VGA_G, VGA_B;

    int n_chk = 0;
    int n_fail = 0;

    logic [2:0] img [0:7][0:11];
    logic [2:0] obs [0:31][0:47];

    vga_scanout #(
        .H_VIS(H_VIS), .H_FP(H_FP), .H_SW(H_SW), .H_BP(H_BP),
        .V_VIS(V_VIS), .V_FP(V_FP), .V_SW(V_SW), .V_BP(V_BP),
        .FB_W(160), .FB_H(120)
    ) dut (
        .clk(clk), .reset(reset),
        .x(x), .y(y), .colour(colour), .plot(plot), .clear(clear),
        .clear_busy(clear_busy), .frame_start(frame_start),
        .VGA_CLK(VGA_CLK), .VGA_HS(VGA_HS), .VGA_VS(VGA_VS),
        .VGA_BLANK_N(VGA_BLANK_N), .VGA_SYNC_N(VGA_SYNC_N),
        .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_plot(input int px, input int py, input logic [2:0] c);
        @(negedge clk);
        x = 10'(px);
        y = 10'(py);
        colour = c;
        plot = 1'b1;
        @(negedge clk);
        plot = 1'b0;
    endtask

    task automatic wait_fs(input string tag);
        int n;
        n = 0;
        while (!frame_start && n < 6000) begin
            tick();
            n++;
        end
        check(tag, frame_start, 1'b1);
    endtask

    // Scan one frame; pixel (h,v) appears 4 + 2*(v*H_TOT+h) clk after the wrap edge
    task automatic scan_frame(input string tag, output int bad_rgb,
                              output int bad_tim, output int lit);
        logic [2:0] c;
        logic       vis, ehs, evs;
        bad_rgb = 0;
        bad_tim = 0;
        lit = 0;
        wait_fs(tag);
        repeat (3) @(posedge clk);
        tick();
        for (int v = 0; v < V_TOT; v++) begin
            for (int h = 0; h < H_TOT; h++) begin
                if (v != 0 || h != 0) begin
                    @(posedge clk);
                    tick();
                end
                vis = (h < H_VIS) && (v < V_VIS);
                ehs = !(h >= 52 && h <= 59);
                evs = !(v >= 34 && v <= 35);
                if (vis) c = img[v/4][h/4];
                else c = 3'b000;
                if (vis) obs[v][h] = {VGA_R[0], VGA_G[0], VGA_B[0]};
                if ({VGA_R, VGA_G, VGA_B} !==
                    {{10{c[2]}}, {10{c[1]}}, {10{c[0]}}}) bad_rgb++;
                if (VGA_BLANK_N !== vis || VGA_HS !== ehs ||
                    VGA_VS !== evs || VGA_SYNC_N !== 1'b1) bad_tim++;
                if (vis && (|{VGA_R, VGA_G, VGA_B})) lit++;
            end
        end
    endtask

    initial begin
        int n, n2, vs_cnt, hs_cnt, bad_sync;
        int b_rgb, b_tim, lit;
        logic fs_after;

        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 12; c++)
                img[r][c] = 3'b000;

        // reset state
        repeat (3) tick();
        check("rst_hs", VGA_HS, 1'b1);
        check("rst_vs", VGA_VS, 1'b1);
        check("rst_blank_n", VGA_BLANK_N, 1'b0);
        check("rst_r", VGA_R, 10'h0);
        check("rst_g", VGA_G, 10'h0);
        check("rst_b", VGA_B, 10'h0);
        check("rst_fs", frame_start, 1'b0);
        check("rst_clr_busy", clear_busy, 1'b0);
        check("rst_vga_clk", VGA_CLK, 1'b0);
        check("rst_sync_n", VGA_SYNC_N, 1'b1);
        @(negedge clk);
        reset = 1'b0;

        // horizontal sync timing
        n = 0;
        while (VGA_HS && n < 400) begin tick(); n++; end
        check("hs_first_fall", n, 108);
        n = 0;
        while (!VGA_HS && n < 400) begin tick(); n++; end
        check("hs_low_width", n, 16);
        n2 = 0;
        while (VGA_HS && n2 < 400) begin tick(); n2++; end
        check("hs_period", n + n2, 128);

        // frame pacing, vsync width, sync_n constant
        wait_fs("fs_first");
        n = 0; vs_cnt = 0; hs_cnt = 0; bad_sync = 0; fs_after = 1'bx;
        while (n < 6000) begin
            tick();
            n++;
            if (n == 1) fs_after = frame_start;
            if (frame_start) break;
            if (!VGA_VS) vs_cnt++;
            if (!VGA_HS) hs_cnt++;
            if (VGA_SYNC_N !== 1'b1) bad_sync++;
        end
        if (!VGA_VS) vs_cnt++;
        if (!VGA_HS) hs_cnt++;
        check("fs_width", fs_after, 1'b0);
        check("fs_period", n, 4864);
        check("vs_low_clk", vs_cnt, 256);
        check("hs_low_frame", hs_cnt, 608);
        check("sync_n_const", bad_sync, 0);

        // one in-range plot plus two out-of-range plots
        do_plot(5, 7, 3'b101);
        do_plot(160, 0, 3'b111);
        do_plot(0, 120, 3'b111);
        img[7][5] = 3'b101;
        scan_frame("f1_sync", b_rgb, b_tim, lit);
        check("f1_rgb_bad", b_rgb, 0);
        check("f1_tim_bad", b_tim, 0);
        check("f1_lit", lit, 16);
        check("f1_px_20_28", obs[28][20], 3'b101);
        check("f1_px_23_31", obs[31][23], 3'b101);
        check("f1_px_21_27", obs[27][21], 3'b000);
        check("f1_px_24_28", obs[28][24], 3'b000);
        check("f1_fb_0_0", obs[0][0], 3'b000);
        check("f1_fb_0_1", obs[4][0], 3'b000);

        // plot on the very edge the scan reads (x=2,y=3 -> h=8,v=12)
        wait_fs("sc_sync");
        repeat (1 + 2 * 776) @(posedge clk);
        @(negedge clk);
        x = 10'd2; y = 10'd3; colour = 3'b010; plot = 1'b1;
        @(posedge clk);
        #1 plot = 1'b0;
        @(posedge clk);
        tick();
        check("sc_old_g", VGA_G, 10'h000);
        check("sc_old_blank", VGA_BLANK_N, 1'b1);
        @(posedge clk);
        tick();
        check("sc_new_g", VGA_G, 10'h3FF);
        img[3][2] = 3'b010;
        scan_frame("f2_sync", b_rgb, b_tim, lit);
        check("f2_rgb_bad", b_rgb, 0);
        check("f2_tim_bad", b_tim, 0);
        check("f2_lit", lit, 32);
        check("f2_px_8_12", obs[12][8], 3'b010);

        // reset in the middle of a lit pixel
        wait_fs("mr_sync");
        repeat (3627) @(posedge clk);
        tick();
        check("mr_pre_r", VGA_R, 10'h3FF);
        #2 reset = 1'b1;
        #1;
        check("mr_r", VGA_R, 10'h0);
        check("mr_b", VGA_B, 10'h0);
        check("mr_blank_n", VGA_BLANK_N, 1'b0);
        check("mr_hs", VGA_HS, 1'b1);
        check("mr_vs", VGA_VS, 1'b1);
        check("mr_vga_clk", VGA_CLK, 1'b0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        n = 0;
        while (VGA_HS && n < 400) begin tick(); n++; end
        check("mr_hs_refall", n, 108);
        scan_frame("f3_sync", b_rgb, b_tim, lit);
        check("f3_rgb_bad", b_rgb, 0);
        check("f3_tim_bad", b_tim, 0);
        check("f3_lit", lit, 32);

`ifdef SCANOUT_CLEAR_EN
        @(negedge clk);
        clear = 1'b1;
        @(posedge clk);
        #1 clear = 1'b0;
        check("clr_busy_rise", clear_busy, 1'b1);
        n = 0;
        while (clear_busy && n < 20000) begin
            n++;
            if (n == 100) begin
                @(negedge clk);
                x = 10'd1; y = 10'd1; colour = 3'b111; plot = 1'b1;
            end
            tick();
            plot = 1'b0;
        end
        check("clr_busy_len", n, 19200);
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 12; c++)
                img[r][c] = 3'b000;
        scan_frame("f4_sync", b_rgb, b_tim, lit);
        check("f4_rgb_bad", b_rgb, 0);
        check("f4_lit", lit, 0);
`else
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        n = 0;
        repeat (50) begin
            tick();
            if (clear_busy !== 1'b0) n++;
        end
        check("clr_busy_tied", n, 0);
`endif

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule

// File: doc/vga_scanout.md
Name: vga_scanout

Overview:
- Display-side consumer of the game's plot stream (x, y, colour, plot), i.e. the drawing engines' interface seen from the receiving end.
- Stores each plotted pixel in an internal 160x120x3-bit framebuffer.
- Continuously reads the framebuffer out as 640x480@60 Hz VGA; each stored pixel covers a 4x4 block of screen pixels.
- Sits between the draw multiplexer and the board DAC pins; also supplies a frame_start tick for game pacing.

Parameters:
- H_VIS, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SW, 96, horizontal sync width
- H_BP, 48, horizontal back porch
- V_VIS, 480, visible lines
- V_FP, 10, vertical front porch
- V_SW, 2, vertical sync width
- V_BP, 33, vertical back porch
- FB_W, 160, framebuffer width
- FB_H, 120, framebuffer height

Ports:
- clk  in  1  50 MHz system clock
- reset  in  1  asynchronous, active-high reset
- x  in  10  plot column
- y  in  10  plot row
- colour  in  3  {R,G,B} plot colour
- plot  in  1  write strobe, one pixel per cycle
- clear  in  1  framebuffer clear request (used only with optional feature)
- clear_busy  out  1  clear in progress
- frame_start  out  1  one-cycle pulse at start of each frame
- VGA_CLK  out  1  25 MHz pixel clock
- VGA_HS  out  1  horizontal sync, active low
- VGA_VS  out  1  vertical sync, active low
- VGA_BLANK_N  out  1  high in the visible region
- VGA_SYNC_N  out  1  constant 1
- VGA_R  out  10  red
- VGA_G  out  10  green
- VGA_B  out  10  blue

Behaviour:
- Reset values: VGA_HS=1, VGA_VS=1, VGA_BLANK_N=0, RGB=0, frame_start=0, clear_busy=0. Pixel-enable toggle, hcount and vcount all 0.
- Framebuffer contents are not reset; initial contents are all zero (black).
- Pixel enable:
  - pix_en toggles every clk.
  - VGA_CLK = registered pix_en.
  - All scan logic advances only on cycles where pix_en=1.
- Counters:
  - hcount runs 0..799 and wraps to 0.
  - vcount increments when hcount wraps; it runs 0..524 and wraps to 0.
- Write port:
  - When plot=1 and x<160 and y<120: write mem[y*160+x]=colour on that clk edge.
  - Address is computed as (y<<7)+(y<<5)+x, 15 bits.
  - Out-of-range writes are discarded; they never alias to another pixel.
- Read path (3-stage pipeline, in pixel-enable ticks):
  - Stage 0: counters. Read address = (vcount>>2)*160 + (hcount>>2), formed only when hcount<640 and vcount<480.
  - Stage 1: registered RAM read. HS, VS and blank terms are delayed alongside it.
  - Stage 2: outputs registered.
  - Total latency is 2 pixel ticks. Sync and blank are delayed identically, so colour and timing stay aligned.
- Output timing:
  - VGA_HS low for stage-0 hcount in 656..751.
  - VGA_VS low for stage-0 vcount in 490..491.
  - VGA_BLANK_N = (hcount<640 && vcount<480).
  - Each colour bit is replicated to all 10 bits of its channel.
  - RGB is forced to 0 when blanked.
- frame_start: high for exactly one clk on the pix_en cycle where the counters wrap from (799,524) to (0,0).
- Simultaneous write and read of the same address: the read returns the old data. The new data appears on the next frame.
- Reset asserted mid-frame: counters and outputs return to reset values immediately; the framebuffer is retained.

Optional Feature:
- Macro: SCANOUT_CLEAR_EN
- Defined:
  - A clear pulse sets clear_busy=1 and starts an address counter at 0.
  - Each clk, 0 is written to the current address; the counter stops after address 19199.
  - clear_busy falls on the clk after the final write, 19200 clk after the clear pulse.
  - Plot writes while clear_busy=1 are dropped; clear has priority.
  - clear while busy restarts the counter at 0.
  - reset aborts the clear and sets clear_busy=0.
- Undefined: the clear input is ignored, clear_busy is tied to 0, and no clear logic is synthesised.

Test Plan:
- Reset, then release -> all outputs at reset values. First HS low edge at clk 2*(656+2) after release. VGA_SYNC_N=1 throughout.
- Free-run one frame -> HS low for 192 clk out of every 1600. VS low for 3200 clk out of every 840000. frame_start spacing is exactly 840000 clk.
- plot (x=5, y=7, colour=3'b101), then wait one frame -> VGA_R=VGA_B=10'h3FF and VGA_G=0 for hcount 20..23, vcount 28..31. Black everywhere else.
- plot (x=160, y=0, colour=3'b111) and (x=0, y=120, colour=3'b111) -> no visible change anywhere. In particular (0,1) and (0,0) stay black.
- plot in the same cycle the scan reads that address -> old colour this frame, new colour the next frame.
- With SCANOUT_CLEAR_EN: fill pixels, then pulse clear -> clear_busy high for 19200 clk. A plot at cycle 100 of the clear is dropped. The next frame is fully black.
